// File: rtl/core_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming
// convolution / bias / activation / max-pool core.
package core_stream_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10
    } act_e;

    function automatic int accw(
        input int dwidth,
        input int taps
    );
        return 2 * dwidth + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 dwidth
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dwidth - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dwidth - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Pool edge 0 behaves as 1; oversize requests clamp.
    function automatic int pool_edge(
        input int req,
        input int maxp
    );
        if (req <= 0) begin
            return 1;
        end
        if (req > maxp) begin
            return maxp;
        end
        return req;
    endfunction

endpackage

// File: rtl/core_pool_max.sv
// Running max over a P x P group of samples with a
// valid/ready output register.
module core_pool_max
    import core_stream_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int LWIDTH  = 10,
    parameter int MAXPOOL = 3
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     clear,
    input  logic [LWIDTH-1:0]        w_pool_size,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] out_data,
    output logic                     active
);

    localparam int CW = $clog2(MAXPOOL * MAXPOOL + 1);

    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic [CW-1:0]            last_cnt;
    logic signed [DWIDTH-1:0] max_q;
    logic signed [DWIDTH-1:0] max_d;
    logic signed [DWIDTH-1:0] out_q;
    logic signed [DWIDTH-1:0] out_d;
    logic signed [DWIDTH-1:0] cur;
    logic                     ov_q;
    logic                     ov_d;
    logic                     adv;
    logic                     take;
    logic                     last;
    int                       edge_p;

    assign adv       = !ov_q || out_ready;
    assign take      = in_valid && adv;
    assign out_valid = ov_q;
    assign out_data  = out_q;
    assign active    = (cnt_q != '0);

    always_comb begin
        edge_p   = pool_edge(int'(w_pool_size), MAXPOOL);
        last_cnt = CW'(edge_p * edge_p - 1);
    end

    // >= keeps a shrinking pool size from stranding the counter.
    assign last = (cnt_q >= last_cnt);
    assign cur  = (cnt_q == '0 || in_data > max_q) ? in_data : max_q;

    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
        ov_d  = ov_q;
        out_d = out_q;
        if (adv) begin
            ov_d = 1'b0;
        end
        if (take) begin
            if (last) begin
                ov_d  = 1'b1;
                out_d = cur;
                cnt_d = '0;
            end else begin
                max_d = cur;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            cnt_q <= '0;
            max_q <= '0;
            ov_q  <= 1'b0;
            out_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            max_q <= '0;
            ov_q  <= 1'b0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
            ov_q  <= ov_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/core_stream.sv
// Streaming conv window -> round/scale -> bias/saturate
// -> activation -> max-pool core with valid/ready flow.
module core_stream
    import core_stream_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int FSIZE   = 5,
    parameter int FRAC    = 8,
    parameter int LWIDTH  = 10,
    parameter int MAXPOOL = 3
) (
    input  logic                                   clk,
    input  logic                                   xrst,
    input  logic                                   clear,
    input  logic                                   wreg_we,
    input  logic                                   breg_we,
    input  logic signed [DWIDTH-1:0]               read_net,
    input  logic [1:0]                             act_mode,
    input  logic [LWIDTH-1:0]                      w_pool_size,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [FSIZE*FSIZE-1:0][DWIDTH-1:0]     pixel,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [DWIDTH-1:0]               pmap,
    output logic                                   busy
);

    localparam int NTAP = FSIZE * FSIZE;
    localparam int ACCW = accw(DWIDTH, NTAP);
    localparam int PWID = 2 * DWIDTH;
    localparam int PW   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int HALF = 1 << (FRAC - 1);

    logic signed [DWIDTH-1:0] weight_q [NTAP];
    logic signed [DWIDTH-1:0] bias_q;
    logic [PW-1:0]            ptr_q;
    logic                     rdy_q;

    logic                     loading;
    logic                     adv;
    logic                     accept;
    logic                     pool_active;

    logic                     s1_v_q;
    logic                     s2_v_q;
    logic                     s3_v_q;
    logic                     s4_v_q;
    logic signed [PWID-1:0]   prod_q [NTAP];
    logic signed [PWID-1:0]   prod_d [NTAP];
    logic signed [ACCW-1:0]   sum_q;
    logic signed [ACCW-1:0]   sum_d;
    logic signed [ACCW-1:0]   rnd;
    logic signed [ACCW-1:0]   biased;
    logic signed [DWIDTH-1:0] sat_q;
    logic signed [DWIDTH-1:0] sat_d;
    logic signed [DWIDTH-1:0] act_q;
    logic signed [DWIDTH-1:0] act_d;

    assign loading  = wreg_we || breg_we;
    assign adv      = !out_valid || out_ready;
    assign in_ready = rdy_q && adv && !loading;
    assign accept   = in_valid && in_ready;

    assign busy = s1_v_q || s2_v_q || s3_v_q || s4_v_q
               || out_valid || pool_active;

    // Weight pointer auto-increments and wraps per window.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            rdy_q  <= 1'b0;
            ptr_q  <= '0;
            bias_q <= '0;
            for (int i = 0; i < NTAP; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (wreg_we) begin
                weight_q[ptr_q] <= read_net;
                ptr_q <= (ptr_q == PW'(NTAP - 1))
                       ? '0 : ptr_q + PW'(1);
            end
            if (breg_we) begin
                bias_q <= read_net;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            prod_d[i] = PWID'($signed(pixel[i]))
                      * PWID'(weight_q[i]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum_d = sum_d + ACCW'(prod_q[i]);
        end
    end

    always_comb begin
        rnd    = (sum_q + ACCW'(HALF)) >>> FRAC;
        biased = rnd + ACCW'(bias_q);
        sat_d  = DWIDTH'(saturate(64'(biased), DWIDTH));
    end

    // Mode 11 falls through to relu.
    always_comb begin
        act_d = sat_q;
        case (act_mode)
            ACT_NONE:  act_d = sat_q;
            ACT_LEAKY: act_d = sat_q[DWIDTH-1]
                             ? (sat_q >>> 3) : sat_q;
            default:   act_d = sat_q[DWIDTH-1]
                             ? '0 : sat_q;
        endcase
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            s4_v_q <= 1'b0;
        end else if (clear) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            s4_v_q <= 1'b0;
        end else if (adv) begin
            s1_v_q <= accept;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            s4_v_q <= s3_v_q;
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            for (int i = 0; i < NTAP; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
            sat_q <= '0;
            act_q <= '0;
        end else if (adv) begin
            for (int i = 0; i < NTAP; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sum_q <= sum_d;
            sat_q <= sat_d;
            act_q <= act_d;
        end
    end

    core_pool_max #(
        .DWIDTH  (DWIDTH),
        .LWIDTH  (LWIDTH),
        .MAXPOOL (MAXPOOL)
    ) u_pool (
        .clk         (clk),
        .xrst        (xrst),
        .clear       (clear),
        .w_pool_size (w_pool_size),
        .in_valid    (s4_v_q),
        .in_data     (act_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (pmap),
        .active      (pool_active)
    );

endmodule

// File: tb/tb_core_stream.sv
// Scoreboard bench for core_stream: directed cases plus
// a randomized stream against a behavioural model.
module tb_core_stream;

    localparam int DW   = 16;
    localparam int NTAP = 25;
    localparam int FRAC = 8;
    localparam int LW   = 10;
    localparam int MAXP = 3;

    logic                      clk = 1'b0;
    logic                      xrst;
    logic                      clear;
    logic                      wreg_we;
    logic                      breg_we;
    logic signed [DW-1:0]      read_net;
    logic [1:0]                act_mode;
    logic [LW-1:0]             w_pool_size;
    logic                      in_valid;
    logic                      in_ready;
    logic [NTAP-1:0][DW-1:0]   pixel;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DW-1:0]      pmap;
    logic                      busy;

    int     n_chk = 0;
    int     n_err = 0;
    longint expq[$];
    int     mw[NTAP];
    int     mb;
    int     win[NTAP];
    int     mcnt;
    longint mmax;
    int     out_cnt = 0;
    int     bp_mode = 0;
    bit     held = 0;
    longint held_val;
    int     lat;
    int     c0;

    core_stream dut (
        .clk         (clk),
        .xrst        (xrst),
        .clear       (clear),
        .wreg_we     (wreg_we),
        .breg_we     (breg_we),
        .read_net    (read_net),
        .act_mode    (act_mode),
        .w_pool_size (w_pool_size),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pixel       (pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pmap        (pmap),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model_px(input int pix[NTAP],
                                        input int act);
        longint s;
        s = 0;
        for (int i = 0; i < NTAP; i++) begin
            s += longint'(pix[i]) * longint'(mw[i]);
        end
        s = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        s += mb;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (act == 2) begin
            if (s < 0) s = s >>> 3;
        end else if (act != 0) begin
            if (s < 0) s = 0;
        end
        return s;
    endfunction

    task automatic model_pool(input longint v);
        int p;
        p = (w_pool_size == 0) ? 1
          : (w_pool_size > MAXP) ? MAXP : int'(w_pool_size);
        if (mcnt == 0 || v > mmax) mmax = v;
        if (mcnt >= p * p - 1) begin
            expq.push_back(mmax);
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    // mode 0: no expectation, 1: push expv, 2: use model
    task automatic send(input int pix[NTAP], input int mode,
                        input longint expv);
        bit acc;
        for (int i = 0; i < NTAP; i++) pixel[i] = DW'(pix[i]);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            #1;
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("send_timeout", longint'(acc), 1);
            return;
        end
        if (mode == 1) expq.push_back(expv);
        else if (mode == 2) model_pool(model_px(pix, int'(act_mode)));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 400) begin
            tick();
            t++;
        end
        if (busy) check("idle_timeout", longint'(busy), 0);
    endtask

    task automatic load_w();
        for (int i = 0; i < NTAP; i++) begin
            wreg_we  = 1'b1;
            read_net = DW'(mw[i]);
            if (i == 0) begin
                #1;
                check("load_gate", longint'(in_ready), 0);
            end
            tick();
        end
        wreg_we = 1'b0;
    endtask

    task automatic load_b(input int b);
        breg_we  = 1'b1;
        read_net = DW'(b);
        mb       = b;
        tick();
        breg_we  = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NTAP; i++) win[i] = v;
    endtask

    task automatic onehot(input int v);
        for (int i = 0; i < NTAP; i++) win[i] = 0;
        win[0] = v;
    endtask

    task automatic set_w(input int v);
        for (int i = 0; i < NTAP; i++) mw[i] = v;
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else if (bp_mode == 0) out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (xrst) begin
            held = 0;
        end else if (out_valid) begin
            if (held) check("hold_pmap", pmap, held_val);
            if (!out_ready) begin
                check("stall_in_ready", longint'(in_ready), 0);
                held     = 1;
                held_val = pmap;
            end else begin
                held = 0;
                out_cnt++;
                check("out_expected", longint'(expq.size() != 0), 1);
                if (expq.size() != 0) check("pmap", pmap, expq.pop_front());
            end
        end else begin
            if (held) check("hold_valid", longint'(out_valid), 1);
            held = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xrst = 1'b1; clear = 1'b0; wreg_we = 1'b0; breg_we = 1'b0;
        read_net = '0; act_mode = 2'd1; w_pool_size = LW'(1);
        in_valid = 1'b0; pixel = '0; out_ready = 1'b1;
        mcnt = 0; mmax = 0; mb = 0;
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_pmap", pmap, 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        xrst = 1'b0;
        check("rdy_before_edge", longint'(in_ready), 0);
        tick();
        check("rdy_after_edge", longint'(in_ready), 1);

        // unit gain and latency
        set_w(256); load_w(); load_b(10);
        act_mode = 2'd1;
        fill(1); send(win, 1, 35);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 5);
        wait_idle();

        // negative path through each activation
        load_b(0); fill(-4);
        act_mode = 2'd1; send(win, 1, 0);    wait_idle();
        act_mode = 2'd2; send(win, 1, -13);  wait_idle();
        act_mode = 2'd0; send(win, 1, -100); wait_idle();

        // saturation both ways
        set_w(32767); load_w();
        fill(32767);  send(win, 1, 32767);  wait_idle();
        fill(-32768); send(win, 1, -32768); wait_idle();

        // pooling: 2x2, size 0 as 1, oversize clamps to 3
        set_w(256); load_w();
        w_pool_size = LW'(2);
        c0 = out_cnt;
        onehot(3);  send(win, 0, 0);
        onehot(9);  send(win, 0, 0);
        onehot(-1); send(win, 0, 0);
        onehot(7);  send(win, 1, 9);
        wait_idle();
        check("pool2_count", out_cnt - c0, 1);
        w_pool_size = LW'(0);
        c0 = out_cnt;
        onehot(3);  send(win, 1, 3);
        onehot(9);  send(win, 1, 9);
        onehot(-1); send(win, 1, -1);
        onehot(7);  send(win, 1, 7);
        wait_idle();
        check("pool0_count", out_cnt - c0, 4);
        w_pool_size = LW'(7);
        c0 = out_cnt;
        for (int k = 0; k < 9; k++) begin
            onehot(k * 7 % 9 - 4);
            send(win, (k == 8) ? 1 : 0, 4);
        end
        wait_idle();
        check("pool_clamp_count", out_cnt - c0, 1);

        // forced 3-cycle stall while streaming
        w_pool_size = LW'(1);
        bp_mode = 2;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    onehot(k * 3 - 5);
                    send(win, 1, k * 3 - 5);
                end
            end
            begin
                repeat (6) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // random stream against the model with random backpressure
        for (int i = 0; i < NTAP; i++) mw[i] = int'($urandom_range(0, 600)) - 300;
        load_w();
        load_b(int'($urandom_range(0, 2000)) - 1000);
        bp_mode = 1;
        for (int b = 0; b < 4; b++) begin
            wait_idle();
            act_mode    = 2'(b);
            w_pool_size = LW'((b == 3) ? 1 : b + 1);
            mcnt = 0;
            for (int n = 0; n < ((b == 3) ? 42 : (b == 2) ? 54 : 52); n++) begin
                for (int i = 0; i < NTAP; i++) win[i] = int'($urandom_range(0, 4000)) - 2000;
                send(win, 2, 0);
            end
        end
        wait_idle();
        bp_mode = 0;
        tick();

        // clear flushes partial pool and a same-cycle acceptance
        set_w(256); load_w(); load_b(0);
        act_mode = 2'd0; w_pool_size = LW'(2);
        onehot(20); send(win, 0, 0);
        onehot(30); send(win, 0, 0);
        onehot(40); send(win, 0, 0);
        onehot(50);
        for (int i = 0; i < NTAP; i++) pixel[i] = DW'(win[i]);
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", longint'(busy), 0);
        check("clear_out_valid", longint'(out_valid), 0);
        check("clear_pmap", pmap, 0);
        c0 = out_cnt;
        onehot(5); send(win, 0, 0);
        onehot(2); send(win, 0, 0);
        onehot(8); send(win, 0, 0);
        onehot(1); send(win, 1, 8);
        wait_idle();
        check("clear_count", out_cnt - c0, 1);

        // async reset mid-window restores weights, bias, pointer
        load_b(7);
        for (int i = 0; i < 3; i++) begin
            wreg_we = 1'b1;
            read_net = DW'(256);
            tick();
        end
        wreg_we = 1'b0;
        onehot(11); send(win, 0, 0);
        onehot(12); send(win, 0, 0);
        #3;
        xrst = 1'b1;
        #1;
        check("xrst_out_valid", longint'(out_valid), 0);
        check("xrst_pmap", pmap, 0);
        check("xrst_busy", longint'(busy), 0);
        check("xrst_in_ready", longint'(in_ready), 0);
        #3;
        xrst = 1'b0;
        tick();
        check("xrst_rdy_up", longint'(in_ready), 1);
        w_pool_size = LW'(1);
        fill(100); send(win, 1, 0);
        wait_idle();
        wreg_we = 1'b1;
        read_net = DW'(256);
        tick();
        wreg_we = 1'b0;
        onehot(5); send(win, 1, 5);
        wait_idle();
        repeat (3) tick();

        check("scoreboard_drain", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/core_stream.md
Name: core_stream

Overview:
- Parametrised successor of the fixed conv→bias→relu→pool core.
- Computes one FSIZE×FSIZE convolution window per accepted input, then:
  - rounds and scales the fixed-point sum;
  - adds bias and saturates;
  - applies a run-time selectable activation;
  - max-pools over a run-time pool size up to MAXPOOL×MAXPOOL.
- Full valid/ready streaming with backpressure replaces the external *_oe strobes.
- Sits between the window buffer and the feature-memory writer.

Parameters:
- DWIDTH 16: data width, signed two's complement.
- FSIZE 5: convolution kernel edge; the window has FSIZE**2 taps.
- FRAC 8: fraction bits of the weight/pixel fixed-point format.
- LWIDTH 10: width of the size configuration input.
- MAXPOOL 3: largest supported pool edge.

Ports:
- clk  in  1  clock, rising edge.
- xrst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush of pipeline and pool state; weights and bias are kept.
- wreg_we  in  1  write read_net into the weight register at the weight pointer.
- breg_we  in  1  write read_net into the bias register.
- read_net  in  DWIDTH  weight/bias load data, signed.
- act_mode  in  2  00 none, 01 relu, 10 leaky (x>>>3 for x<0), 11 treated as relu.
- w_pool_size  in  LWIDTH  pool edge; 0 is treated as 1, values >MAXPOOL clamp to MAXPOOL.
- in_valid  in  1  pixel window valid.
- in_ready  out  1  window accepted when in_valid && in_ready.
- pixel  in  [FSIZE**2] x DWIDTH  window taps, signed.
- out_valid  out  1  pmap valid.
- out_ready  in  1  downstream accepts pmap.
- pmap  out  DWIDTH  pooled result, signed.
- busy  out  1  OR of all stage valids and pool counter != 0.

Behaviour:
- Reset (xrst=1, async):
  - Outputs: out_valid=0, pmap=0, busy=0, in_ready=0.
  - Internal: weights=0, bias=0, weight pointer=0, pool counter=0.
  - in_ready rises on the first clk edge after xrst deasserts.
- Weight load:
  - Each wreg_we cycle writes weight[ptr] and then increments ptr.
  - ptr wraps from FSIZE**2-1 to 0.
  - The k-th write after reset or wrap lands in tap k.
- Load gating: in_ready=0 in any cycle where wreg_we or breg_we is high.
- Load ordering: the controller drives wreg_we/breg_we only while busy=0. Loads issued while busy give undefined in-flight results but do not corrupt state.
- Pipeline, advancing when adv = !out_valid || out_ready:
  - S1: FSIZE**2 signed products, each 2*DWIDTH wide.
  - S2: adder tree into an ACCW accumulator, ACCW = 2*DWIDTH + clog2(FSIZE**2). No overflow is possible.
  - S3: round as (sum + 2**(FRAC-1)) >>> FRAC, add sign-extended bias, saturate to [-2**(DWIDTH-1), 2**(DWIDTH-1)-1].
  - S4: activation per act_mode. Leaky floors, e.g. -100 → -13.
  - S5: pool stage.
- in_ready = adv when not loading. With adv=0, every stage and pmap hold.
- Pool stage:
  - P = clamped pool edge; the counter runs 0..P*P-1.
  - Samples arrive window-major (upstream orders them).
  - On count 0, max = sample; otherwise max = max(max, sample).
  - On count P*P-1, pmap = the final max and out_valid=1, and the counter returns to 0.
- Latency, no stalls: out_valid rises 5 cycles after acceptance of the last sample of a window. For P=1, throughput is 1 result/cycle.
- out_valid/pmap stay stable until out_ready. out_valid falls after the handshake unless a new result loads in the same cycle.
- act_mode and w_pool_size are sampled every cycle. They must be stable while busy=1. Changing them mid-window is undefined but never deadlocks; the counter compares with >=.
- clear:
  - Zeroes all stage valids, the pool counter, out_valid and pmap next cycle.
  - Overrides a simultaneous input acceptance.
  - Weights, bias and ptr are unchanged.
- xrst mid-operation: immediate return to reset values, including weights.

Decomposition:
- renkon.svh additions: act_mode enum (ACT_NONE, ACT_RELU, ACT_LEAKY), ACCW localparam function, saturate function.
- Sub-module core_pool_max:
  - Contains the counter, running max and output register with valid/ready.
  - Parameters DWIDTH, MAXPOOL.
  - Ports: clk, xrst, clear, w_pool_size, in valid/data, out valid/ready/data.

Test Plan:
- Unit gain: load all weights 256 and bias 10, pixels all 1, act relu, pool 1 → pmap 35, out_valid 5 cycles after in_valid.
- Negative path: pixels all -4, bias 0, weights 256 → relu gives 0; leaky gives -13; none gives -100.
- Saturation: weights 32767, pixels 32767 → pmap 32767. Weights 32767, pixels -32768 → pmap -32768.
- Pool 2: four windows producing 3, 9, -1, 7 → exactly one output, 9, after the fourth. w_pool_size=0 → four outputs 3, 9, -1, 7.
- Backpressure: out_ready=0 for 3 cycles while streaming → in_ready=0 in those cycles, pmap held, no result lost or duplicated; reference-model compare over 200 random windows.
- Reset/clear: xrst mid-window → immediate reset values and weights 0; clear with pool 2 after 3 samples → no output, next 4 samples produce one correct max, weights retained.
